// File: rtl/vga_fb_arbiter.sv
// Framebuffer RAM arbiter: real-time scanline prefetch for the VGA line buffer,
// with guaranteed host slots interleaved into each fetch and all idle cycles.
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | no line fetch pending; host granted on any new request
// FETCH  | copying one scanline; display has priority, host every burst
module vga_fb_arbiter #(
   parameter int ADDR_WIDTH      = 16,
   parameter int DATA_WIDTH      = 32,
   parameter int WORDS_PER_LINE  = 20,
   parameter int LINES_PER_FRAME = 480,
   parameter int DISP_BURST      = 4,
   parameter int LB_ADDR_WIDTH   = 5
) (
   input  logic                     block_clk_i,
   input  logic                     rst_low_i,
   input  logic                     frame_start_i,
   input  logic                     line_start_i,
   input  logic                     host_req_i,
   input  logic                     host_we_i,
   input  logic [ADDR_WIDTH-1:0]    host_addr_i,
   input  logic [DATA_WIDTH-1:0]    host_wdata_i,
   output logic                     host_ack_o,
   output logic                     host_rvalid_o,
   output logic [DATA_WIDTH-1:0]    host_rdata_o,
   output logic                     mem_en_o,
   output logic                     mem_we_o,
   output logic [ADDR_WIDTH-1:0]    mem_addr_o,
   output logic [DATA_WIDTH-1:0]    mem_wdata_o,
   input  logic [DATA_WIDTH-1:0]    mem_rdata_i,
   output logic                     lb_we_o,
   output logic [LB_ADDR_WIDTH-1:0] lb_addr_o,
   output logic [DATA_WIDTH-1:0]    lb_wdata_o,
   output logic                     fetch_busy_o,
   output logic                     underrun_o
);

   localparam int BW = $clog2(DISP_BURST + 1);
   localparam int LW = $clog2(LINES_PER_FRAME + 1);
   localparam logic [LB_ADDR_WIDTH-1:0] WORD_LAST = LB_ADDR_WIDTH'(WORDS_PER_LINE - 1);
   localparam logic [ADDR_WIDTH-1:0]    LINE_STEP = ADDR_WIDTH'(WORDS_PER_LINE);
   localparam logic [BW-1:0]            BURST_MAX = BW'(DISP_BURST);
   localparam logic [LW-1:0]            LINE_MAX  = LW'(LINES_PER_FRAME);

   typedef enum logic {S_IDLE = 1'b0, S_FETCH = 1'b1} state_t;

   state_t                   state_q, state_d;
   logic [LB_ADDR_WIDTH-1:0] word_cnt_q, word_cnt_d;
   logic [ADDR_WIDTH-1:0]    line_base_q, line_base_d;
   logic [LW-1:0]            line_cnt_q, line_cnt_d;
   logic [BW-1:0]            burst_cnt_q, burst_cnt_d;
   logic                     underrun_q, underrun_d;

   logic                     mem_en_q, mem_en_d;
   logic                     mem_we_q, mem_we_d;
   logic [ADDR_WIDTH-1:0]    mem_addr_q, mem_addr_d;
   logic [DATA_WIDTH-1:0]    mem_wdata_q, mem_wdata_d;
   logic                     host_ack_q, host_ack_d;
   logic                     disp_rd_q, disp_rd_d;
   logic [LB_ADDR_WIDTH-1:0] rd_idx_q, rd_idx_d;

   logic                     lb_we_q, lb_we_d;
   logic [LB_ADDR_WIDTH-1:0] lb_addr_q, lb_addr_d;
   logic                     host_rvalid_q, host_rvalid_d;

   logic                     host_pend;
   logic                     grant_host;
   logic                     grant_disp;
   logic [ADDR_WIDTH-1:0]    disp_addr;

   always_ff @(posedge block_clk_i or negedge rst_low_i) begin
      if (!rst_low_i) begin
         state_q       <= S_IDLE;
         word_cnt_q    <= '0;
         line_base_q   <= '0;
         line_cnt_q    <= '0;
         burst_cnt_q   <= '0;
         underrun_q    <= 1'b0;
         mem_en_q      <= 1'b0;
         mem_we_q      <= 1'b0;
         mem_addr_q    <= '0;
         mem_wdata_q   <= '0;
         host_ack_q    <= 1'b0;
         disp_rd_q     <= 1'b0;
         rd_idx_q      <= '0;
         lb_we_q       <= 1'b0;
         lb_addr_q     <= '0;
         host_rvalid_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         word_cnt_q    <= word_cnt_d;
         line_base_q   <= line_base_d;
         line_cnt_q    <= line_cnt_d;
         burst_cnt_q   <= burst_cnt_d;
         underrun_q    <= underrun_d;
         mem_en_q      <= mem_en_d;
         mem_we_q      <= mem_we_d;
         mem_addr_q    <= mem_addr_d;
         mem_wdata_q   <= mem_wdata_d;
         host_ack_q    <= host_ack_d;
         disp_rd_q     <= disp_rd_d;
         rd_idx_q      <= rd_idx_d;
         lb_we_q       <= lb_we_d;
         lb_addr_q     <= lb_addr_d;
         host_rvalid_q <= host_rvalid_d;
      end
   end

   // Grant effects are applied first; frame/line events then act on the result,
   // so a line finishing in the same cycle as line_start is not an underrun.
   always_comb begin
      state_d     = state_q;
      word_cnt_d  = word_cnt_q;
      line_base_d = line_base_q;
      line_cnt_d  = line_cnt_q;
      burst_cnt_d = burst_cnt_q;
      underrun_d  = underrun_q;

      if (grant_disp) begin
         if (burst_cnt_q != BURST_MAX) begin
            burst_cnt_d = burst_cnt_q + BW'(1);
         end
         if (word_cnt_q == WORD_LAST) begin
            word_cnt_d  = '0;
            line_base_d = line_base_q + LINE_STEP;
            line_cnt_d  = line_cnt_q + LW'(1);
            state_d     = S_IDLE;
         end else begin
            word_cnt_d = word_cnt_q + LB_ADDR_WIDTH'(1);
         end
      end
      if (grant_host) begin
         burst_cnt_d = '0;
      end

      if (frame_start_i) begin
         line_base_d = '0;
         line_cnt_d  = '0;
         word_cnt_d  = '0;
         state_d     = S_IDLE;
      end

      if (line_start_i) begin
         if (state_d == S_FETCH) begin
            underrun_d  = 1'b1;
            line_base_d = line_base_d + LINE_STEP;
            line_cnt_d  = line_cnt_d + LW'(1);
            word_cnt_d  = '0;
            state_d     = (line_cnt_d < LINE_MAX) ? S_FETCH : S_IDLE;
         end else if (line_cnt_d < LINE_MAX) begin
            state_d = S_FETCH;
         end
      end
   end

   always_comb begin
      host_pend  = host_req_i & ~host_ack_q;
      grant_host = 1'b0;
      grant_disp = 1'b0;
      case (state_q)
         S_IDLE:  grant_host = host_pend;
         S_FETCH: begin
            if ((burst_cnt_q == BURST_MAX) && host_pend) grant_host = 1'b1;
            else                                         grant_disp = 1'b1;
         end
         default: ;
      endcase

      disp_addr   = line_base_q + ADDR_WIDTH'(word_cnt_q);
      mem_en_d    = grant_host | grant_disp;
      mem_we_d    = grant_host & host_we_i;
      mem_addr_d  = grant_host ? host_addr_i : (grant_disp ? disp_addr : '0);
      mem_wdata_d = (grant_host & host_we_i) ? host_wdata_i : '0;
      host_ack_d  = grant_host;
      disp_rd_d   = grant_disp;
      rd_idx_d    = grant_disp ? word_cnt_q : '0;

      // Owner tag delayed alongside the RAM read latency steers returning data.
      lb_we_d       = mem_en_q & ~mem_we_q & disp_rd_q;
      host_rvalid_d = mem_en_q & ~mem_we_q & ~disp_rd_q;
      lb_addr_d     = lb_we_d ? rd_idx_q : '0;
   end

   assign host_ack_o    = host_ack_q;
   assign host_rvalid_o = host_rvalid_q;
   assign host_rdata_o  = mem_rdata_i;
   assign mem_en_o      = mem_en_q;
   assign mem_we_o      = mem_we_q;
   assign mem_addr_o    = mem_addr_q;
   assign mem_wdata_o   = mem_wdata_q;
   assign lb_we_o       = lb_we_q;
   assign lb_addr_o     = lb_addr_q;
   assign lb_wdata_o    = mem_rdata_i;
   assign fetch_busy_o  = (state_q == S_FETCH);
   assign underrun_o    = underrun_q;

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Bench for vga_fb_arbiter: directed phases plus random traffic, checked every
// cycle against a grant-level reference model with its own shadow of the RAM.
module tb_vga_fb_arbiter;

   localparam int AW  = 16;
   localparam int DW  = 32;
   localparam int WPL = 20;
   localparam int LPF = 480;
   localparam int DB  = 4;
   localparam int LBW = 5;

   logic           clk = 1'b0;
   logic           rst_n;
   logic           fs, ls, hreq, hwe;
   logic [AW-1:0]  haddr;
   logic [DW-1:0]  hwdata;
   logic [DW-1:0]  mem_rdata;
   logic           host_ack_o, host_rvalid_o, mem_en_o, mem_we_o;
   logic           lb_we_o, fetch_busy_o, underrun_o;
   logic [DW-1:0]  host_rdata_o, mem_wdata_o, lb_wdata_o;
   logic [AW-1:0]  mem_addr_o;
   logic [LBW-1:0] lb_addr_o;

   always #5 clk = ~clk;

   vga_fb_arbiter #(
      .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WORDS_PER_LINE(WPL),
      .LINES_PER_FRAME(LPF), .DISP_BURST(DB), .LB_ADDR_WIDTH(LBW)
   ) dut (
      .block_clk_i(clk), .rst_low_i(rst_n),
      .frame_start_i(fs), .line_start_i(ls),
      .host_req_i(hreq), .host_we_i(hwe), .host_addr_i(haddr), .host_wdata_i(hwdata),
      .host_ack_o(host_ack_o), .host_rvalid_o(host_rvalid_o), .host_rdata_o(host_rdata_o),
      .mem_en_o(mem_en_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
      .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata),
      .lb_we_o(lb_we_o), .lb_addr_o(lb_addr_o), .lb_wdata_o(lb_wdata_o),
      .fetch_busy_o(fetch_busy_o), .underrun_o(underrun_o)
   );

   typedef struct {
      bit            valid;
      bit            host;
      bit            we;
      logic [AW-1:0] addr;
      logic [DW-1:0] wdata;
      logic [LBW-1:0] idx;
      logic [DW-1:0] data;
   } acc_t;

   acc_t          hist[$];
   acc_t          e1, e2;
   logic [DW-1:0] ram     [65536];
   logic [DW-1:0] ref_ram [65536];
   logic [DW-1:0] rd_pend;
   bit            rd_pend_v;
   int            n_cmp, n_err;
   int            hmode;
   bit            m_fetch, m_under;
   int            m_word, m_base, m_line, m_burst;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_fetch = 0; m_under = 0;
      m_word = 0; m_base = 0; m_line = 0; m_burst = 0;
      hist.delete();
   endtask

   // One arbitration decision from the rules: host slot after DB display reads
   // (or any idle cycle), otherwise a display read; then frame/line events.
   task automatic model_step();
      acc_t r;
      bit   pend, hgrant, dgrant;
      r = '{default: '0};
      pend   = hreq && !(hist.size() > 0 && hist[$].valid && hist[$].host);
      hgrant = pend && (!m_fetch || m_burst >= DB);
      dgrant = m_fetch && !hgrant;
      if (hgrant) begin
         r.valid = 1; r.host = 1; r.we = hwe; r.addr = haddr;
         if (hwe) begin
            r.wdata = hwdata;
            ref_ram[haddr] = hwdata;
         end else begin
            r.data = ref_ram[haddr];
         end
         m_burst = 0;
      end
      if (dgrant) begin
         r.valid = 1;
         r.addr  = AW'(m_base + m_word);
         r.idx   = LBW'(m_word);
         r.data  = ref_ram[r.addr];
         m_word++;
         m_burst++;
         if (m_word == WPL) begin
            m_word = 0; m_base += WPL; m_line++; m_fetch = 0;
         end
      end
      if (fs) begin
         m_base = 0; m_line = 0; m_word = 0; m_fetch = 0;
      end
      if (ls) begin
         if (m_fetch) begin
            m_under = 1; m_base += WPL; m_line++; m_word = 0;
            m_fetch = (m_line < LPF);
         end else if (m_line < LPF) begin
            m_fetch = 1;
         end
      end
      hist.push_back(r);
      if (hist.size() > 2) void'(hist.pop_front());
   endtask

   task automatic new_req();
      hreq   = 1'b1;
      hwe    = 1'($urandom_range(0, 1));
      haddr  = AW'($urandom_range(0, 255));
      hwdata = $urandom;
   endtask

   task automatic tick();
      logic [AW-1:0] ea;
      logic [DW-1:0] ew;
      bit            x_lbwe, x_rv;
      @(posedge clk);
      model_step();
      if (rd_pend_v) mem_rdata = rd_pend;
      rd_pend_v = 0;
      #1;
      e1 = hist[$];
      if (hist.size() == 2) e2 = hist[0];
      else                  e2 = '{default: '0};
      ea = e1.valid ? e1.addr : '0;
      ew = (e1.valid && e1.host && e1.we) ? e1.wdata : '0;
      chk("issue", {mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o, host_ack_o},
          {e1.valid, (e1.valid && e1.host && e1.we), ea, ew, (e1.valid && e1.host)});
      x_lbwe = e2.valid && !e2.host;
      x_rv   = e2.valid && e2.host && !e2.we;
      chk("return", {lb_we_o, host_rvalid_o, lb_addr_o},
          {x_lbwe, x_rv, (x_lbwe ? e2.idx : LBW'(0))});
      if (x_lbwe) chk("lb_data", lb_wdata_o, e2.data);
      if (x_rv)   chk("host_rdata", host_rdata_o, e2.data);
      chk("status", {fetch_busy_o, underrun_o}, {m_fetch, m_under});
      if (mem_en_o) begin
         if (mem_we_o) ram[mem_addr_o] = mem_wdata_o;
         else begin
            rd_pend   = ram[mem_addr_o];
            rd_pend_v = 1;
         end
      end
      if (hreq && e1.valid && e1.host) hreq = 1'b0;
      if (!hreq) begin
         if (hmode == 1 && $urandom_range(0, 99) < 30) new_req();
         else if (hmode == 2) new_req();
      end
   endtask

   task automatic cycles(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic line_pulse();
      ls = 1'b1; tick(); ls = 1'b0;
   endtask

   task automatic frame_pulse();
      fs = 1'b1; tick(); fs = 1'b0;
   endtask

   task automatic check_all_zero(input string tag);
      chk({tag, "_issue"}, {mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o, host_ack_o}, '0);
      chk({tag, "_ret"}, {lb_we_o, host_rvalid_o, lb_addr_o, fetch_busy_o, underrun_o}, '0);
      chk({tag, "_data"}, {host_rdata_o, lb_wdata_o}, '0);
   endtask

   initial begin
      n_cmp = 0; n_err = 0; hmode = 0;
      for (int i = 0; i < 65536; i++) begin
         ram[i]     = (i * 32'h9E3779B1) ^ 32'h5A5A0000;
         ref_ram[i] = (i * 32'h9E3779B1) ^ 32'h5A5A0000;
      end
      rst_n = 1'b0; fs = 0; ls = 0; hreq = 0; hwe = 0; haddr = '0; hwdata = '0;
      mem_rdata = '0; rd_pend = '0; rd_pend_v = 0;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      check_all_zero("reset");
      rst_n = 1'b1;
      cycles(2);

      // single host write, request held through the ack cycle
      hmode = 3;
      hreq = 1; hwe = 1; haddr = 16'h0010; hwdata = 32'hA5A5A5A5;
      tick();
      chk("host_write_issue", {host_ack_o, mem_we_o, mem_addr_o, mem_wdata_o},
          {1'b1, 1'b1, 16'h0010, 32'hA5A5A5A5});
      hreq = 1;
      tick();
      chk("held_req_no_reissue", {mem_en_o, host_ack_o}, 2'b00);
      hreq = 0;
      cycles(3);

      // first lines of a frame, no host traffic
      hmode = 0;
      frame_pulse();
      line_pulse();
      cycles(25);
      line_pulse();
      cycles(25);

      // rest of the frame with random host traffic, then vertical blanking;
      // a line plus interleaved host slots needs at most 25 cycles
      hmode = 1;
      for (int l = 2; l < LPF; l++) begin
         line_pulse();
         cycles(27);
      end
      hreq = 0; hmode = 0;
      cycles(4);
      line_pulse();
      cycles(8);
      chk("vblank_no_fetch", {fetch_busy_o, mem_en_o}, 2'b00);

      // host hammering at a comfortable line period
      hmode = 2;
      frame_pulse();
      for (int l = 0; l < 5; l++) begin
         line_pulse();
         cycles(25);
      end
      chk("no_underrun_slow_lines", underrun_o, 1'b0);

      // line period too short: abandoned lines and sticky underrun
      for (int l = 0; l < 3; l++) begin
         line_pulse();
         cycles(9);
      end
      chk("underrun_fast_lines", underrun_o, 1'b1);
      hmode = 0;

      // reset in the middle of a fetch with reads in flight
      fs = 1; ls = 1; tick(); fs = 0; ls = 0;
      cycles(5);
      rst_n = 1'b0;
      mem_rdata = '0; rd_pend_v = 0; hreq = 0;
      #1;
      check_all_zero("mid_fetch_reset");
      model_reset();
      @(posedge clk);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      cycles(3);
      fs = 1; ls = 1; tick(); fs = 0; ls = 0;
      cycles(25);

      // random frame/line/host mix
      hmode = 1;
      for (int c = 0; c < 3000; c++) begin
         fs = ($urandom_range(0, 299) == 0);
         ls = ($urandom_range(0, 14) == 0);
         tick();
      end
      fs = 0; ls = 0; hmode = 0;
      cycles(30);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
